// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a class plus fields into a 32-bit word behind a 2-entry FIFO.
// Optional macro ENC_RANGE_CHECK_EN flags immediates that do not fit their field as illegal.
module instr_encoder #(
    parameter int          CNT_W        = 16,
    parameter logic [31:0] ILLEGAL_WORD = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        OP_LOAD   = 4'd0,
        OP_STORE  = 4'd1,
        OP_OP     = 4'd2,
        OP_BRANCH = 4'd3,
        OP_OPIMM  = 4'd4,
        OP_JAL    = 4'd5,
        OP_JALR   = 4'd6,
        OP_LUI    = 4'd7,
        OP_AUIPC  = 4'd8
    } op_e;

    typedef struct packed {
        logic        illegal;
        logic [31:0] word;
    } entry_t;

    entry_t     enc;
    logic       range_bad;
    entry_t     mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] occ;
    logic       push;
    logic       pop;

`ifdef ENC_RANGE_CHECK_EN
    logic i_fit;
    logic b_fit;
    logic j_fit;

    // A signed value fits an N-bit field when every bit above N-1 copies the sign.
    assign i_fit = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign b_fit = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign j_fit = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

    always_comb begin
        range_bad = 1'b0;
        case (in_op)
            OP_LOAD, OP_STORE, OP_OPIMM, OP_JALR: range_bad = ~i_fit;
            OP_BRANCH:                            range_bad = ~b_fit;
            OP_JAL:                               range_bad = ~j_fit;
            OP_LUI, OP_AUIPC:                     range_bad = |in_imm[11:0];
            default:                              range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        enc = '{illegal: 1'b0, word: 32'h0};
        case (in_op)
            OP_LOAD:   enc.word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            OP_OPIMM:  enc.word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            OP_JALR:   enc.word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            OP_STORE:  enc.word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            OP_OP:     enc.word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            OP_BRANCH: enc.word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                   in_imm[4:1], in_imm[11], 7'b1100011};
            OP_JAL:    enc.word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            OP_LUI:    enc.word = {in_imm[31:12], in_rd, 7'b0110111};
            OP_AUIPC:  enc.word = {in_imm[31:12], in_rd, 7'b0010111};
            default:   enc.illegal = 1'b1;
        endcase
        if (enc.illegal || range_bad) begin
            enc = '{illegal: 1'b1, word: ILLEGAL_WORD};
        end
    end

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready    = (occ != 2'd2);
    assign out_valid   = (occ != 2'd0);
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign out_instr   = out_valid ? mem[rd_ptr].word : 32'h0;
    assign out_illegal = out_valid & mem[rd_ptr].illegal;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ         <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            instr_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr      <= ~rd_ptr;
                instr_count <= instr_count + CNT_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !push) begin
                occ <= occ - 2'd1;
            end
        end
    end

    // NOTE: the storage array is not reset; occupancy gates out_valid and out_* so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc;
        end
    end

endmodule
